// File: rtl/b200_spi_arbiter.sv
// Shares one SPI master engine among NUM_REQ requesters.
// Round-robin grant, optional lock, chip-select gap and watchdog abort.
module b200_spi_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                    bus_clk,
  input  logic                    reset_global,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*8-1:0]    req_ss,
  input  logic [NUM_REQ*6-1:0]    req_len,
  input  logic [NUM_REQ-1:0]      req_lock,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    spi_valid,
  input  logic                    spi_ready,
  output logic [DATA_W-1:0]       spi_data,
  output logic [7:0]              spi_ss,
  output logic [5:0]              spi_len,
  input  logic                    spi_done,
  input  logic [DATA_W-1:0]       spi_rdata,
  output logic                    spi_abort,
  output logic                    busy,
  output logic [1:0]              grant_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam int GP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYC - 1);

  logic [1:0]         state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         grant_q;
  logic               lock_q;
  logic               cur_lock_q;
  logic [WD_W-1:0]    wd_q;
  logic [GP_W-1:0]    gap_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_err_q;
  logic               spi_valid_q;
  logic [DATA_W-1:0]  spi_data_q;
  logic [7:0]         spi_ss_q;
  logic [5:0]         spi_len_q;
  logic               spi_abort_q;

  logic [3:0]         valid_pad;
  logic               found;
  logic [1:0]         win;
  logic [2:0]         cand;
  logic [2:0]         nxt;
  logic [1:0]         nxt_ptr;
  logic [DATA_W-1:0]  sel_data;
  logic [7:0]         sel_ss;
  logic [5:0]         sel_len;
  logic               sel_lock;
  logic               bad;
  logic               wd_hit;

  assign valid_pad = 4'(req_valid);

  // While locked only the owner may win; otherwise scan from ptr_q.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 3'd0;
    if (lock_q) begin
      found = valid_pad[grant_q];
      win   = grant_q;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, ptr_q} + 3'(i);
        if (cand >= 3'(NUM_REQ))
          cand = cand - 3'(NUM_REQ);
        if (!found && valid_pad[cand[1:0]]) begin
          found = 1'b1;
          win   = cand[1:0];
        end
      end
    end
  end

  always_comb begin
    nxt = {1'b0, win} + 3'd1;
    if (nxt >= 3'(NUM_REQ))
      nxt = 3'd0;
    nxt_ptr = nxt[1:0];
  end

  always_comb begin
    sel_data = '0;
    sel_ss   = '0;
    sel_len  = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 2'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_ss   = req_ss[i*8 +: 8];
        sel_len  = req_len[i*6 +: 6];
        sel_lock = req_lock[i];
      end
    end
  end

  assign bad = (sel_len == 6'd0) ||
               (int'(sel_len) > DATA_W) ||
               (sel_ss == 8'd0);

  assign wd_hit = (wd_q == WD_LAST);

  always_ff @(posedge bus_clk or posedge reset_global) begin
    if (reset_global) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      grant_q     <= 2'd0;
      lock_q      <= 1'b0;
      cur_lock_q  <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      spi_valid_q <= 1'b0;
      spi_data_q  <= '0;
      spi_ss_q    <= '0;
      spi_len_q   <= '0;
      spi_abort_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      spi_abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            grant_q    <= win;
            cur_lock_q <= sel_lock;
            wd_q       <= '0;
            if (!lock_q)
              ptr_q <= nxt_ptr;
            if (bad) begin
              rsp_valid_q <= NUM_REQ'(1) << win;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              lock_q      <= 1'b0;
              gap_q       <= GP_LAST;
              state_q     <= S_GAP;
            end else begin
              spi_data_q  <= sel_data;
              spi_ss_q    <= sel_ss;
              spi_len_q   <= sel_len;
              spi_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end else if (lock_q && !valid_pad[grant_q]) begin
            // Owner went quiet: release the lock after TIMEOUT idle cycles.
            if (wd_hit) begin
              lock_q <= 1'b0;
              wd_q   <= '0;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end else begin
            wd_q <= '0;
          end
        end
        S_ISSUE: begin
          if (wd_hit) begin
            spi_valid_q <= 1'b0;
            spi_abort_q <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            lock_q      <= 1'b0;
            gap_q       <= GP_LAST;
            state_q     <= S_GAP;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (spi_ready) begin
              spi_valid_q <= 1'b0;
              state_q     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (spi_done) begin
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= spi_rdata;
            lock_q      <= cur_lock_q;
            gap_q       <= GP_LAST;
            state_q     <= S_GAP;
          end else if (wd_hit) begin
            spi_abort_q <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            lock_q      <= 1'b0;
            gap_q       <= GP_LAST;
            state_q     <= S_GAP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
          wd_q <= '0;
          if (gap_q == '0)
            state_q <= S_IDLE;
          else
            gap_q <= gap_q - 1'b1;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE && found && !reset_global)
                   ? (NUM_REQ'(1) << win) : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign spi_valid = spi_valid_q;
  assign spi_data  = spi_data_q;
  assign spi_ss    = spi_ss_q;
  assign spi_len   = spi_len_q;
  assign spi_abort = spi_abort_q;
  assign busy      = (state_q != S_IDLE) || lock_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_b200_spi_arbiter.sv
// Directed bench for b200_spi_arbiter with a behavioural SPI engine.
// Events are logged on the falling edge and checked against hand values.
module tb_b200_spi_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int GAP = 4;
  localparam int TO = 64;

  logic          bus_clk = 1'b0;
  logic          reset_global = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*8-1:0]  req_ss = '0;
  logic [NR*6-1:0]  req_len = '0;
  logic [NR-1:0] req_lock = '0;
  logic [NR-1:0] rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          spi_valid;
  logic          spi_ready = 1'b1;
  logic [DW-1:0] spi_data;
  logic [7:0]    spi_ss;
  logic [5:0]    spi_len;
  logic          spi_done = 1'b0;
  logic [DW-1:0] spi_rdata = '0;
  logic          spi_abort;
  logic          busy;
  logic [1:0]    grant_id;

  b200_spi_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYC(GAP), .TIMEOUT(TO)
  ) dut (
    .bus_clk(bus_clk), .reset_global(reset_global),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_ss(req_ss), .req_len(req_len),
    .req_lock(req_lock), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_valid(spi_valid), .spi_ready(spi_ready),
    .spi_data(spi_data), .spi_ss(spi_ss), .spi_len(spi_len),
    .spi_done(spi_done), .spi_rdata(spi_rdata),
    .spi_abort(spi_abort), .busy(busy), .grant_id(grant_id)
  );

  always #5 bus_clk = ~bus_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // falling-edge event log
  int cyc = 0;
  int nrise = 0;
  int rise_log [64];
  int ngnt = 0;
  int gnt_log [64];
  int gnt_cyc [64];
  int rsp_cnt = 0;
  int rsp_cyc = 0;
  logic [NR-1:0] rsp_vec;
  logic          rsp_e;
  logic [DW-1:0] rsp_d;
  int abort_cnt = 0;
  int abort_cyc = 0;
  logic prev_sv = 1'b0;

  always @(negedge bus_clk) begin
    cyc++;
    if (spi_valid && !prev_sv && nrise < 64) begin
      rise_log[nrise] = cyc;
      nrise++;
    end
    prev_sv = spi_valid;
    if (|req_ready && ngnt < 64) begin
      gnt_log[ngnt] = req_ready[1] ? 1 : 0;
      gnt_cyc[ngnt] = cyc;
      ngnt++;
    end
    if (|rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_vec = rsp_valid;
      rsp_e   = rsp_err;
      rsp_d   = rsp_data;
    end
    if (spi_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
  end

  // SPI engine: accepts when spi_valid, pulses done after eng_delay cycles
  int eng_delay = 1;
  bit eng_hang = 1'b0;
  logic [DW-1:0] eng_rdata = '0;
  int cmd_cnt = 0;
  logic [DW-1:0] cmd_data;
  logic [7:0]    cmd_ss;
  logic [5:0]    cmd_len;

  initial begin
    forever begin
      @(negedge bus_clk);
      if (spi_valid && spi_ready) begin
        cmd_cnt++;
        cmd_data = spi_data;
        cmd_ss   = spi_ss;
        cmd_len  = spi_len;
        if (!eng_hang) begin
          repeat (eng_delay) @(negedge bus_clk);
          spi_rdata = eng_rdata;
          spi_done  = 1'b1;
          @(negedge bus_clk);
          spi_done  = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int id, input logic [DW-1:0] d,
                         input logic [7:0] ss, input logic [5:0] len,
                         input logic lk);
    req_data[id*DW +: DW] = d;
    req_ss[id*8 +: 8]     = ss;
    req_len[id*6 +: 6]    = len;
    req_lock[id]          = lk;
  endtask

  task automatic wait_gnt(input int target, input string tag);
    for (int k = 0; k < 400 && ngnt < target; k++) begin
      @(negedge bus_clk);
      #1;
    end
    check(tag, 64'(ngnt >= target), 64'd1);
  endtask

  task automatic wait_rsp(input int target, input string tag);
    for (int k = 0; k < 400 && rsp_cnt < target; k++) begin
      @(negedge bus_clk);
      #1;
    end
    check(tag, 64'(rsp_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400 && busy; k++) begin
      @(negedge bus_clk);
      #1;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  // single request: raise valid, hold until accepted, then drop
  task automatic issue(input int id, input logic [DW-1:0] d,
                       input logic [7:0] ss, input logic [5:0] len,
                       input logic lk, input string tag);
    int g0;
    g0 = ngnt;
    @(posedge bus_clk);
    #1;
    set_req(id, d, ss, len, lk);
    req_valid[id] = 1'b1;
    wait_gnt(g0 + 1, tag);
    @(posedge bus_clk);
    #1;
    req_valid = '0;
  endtask

  initial begin
    int g0, r0, n0, c0;

    // reset state, with requests already pending
    req_valid = 2'b11;
    set_req(0, 32'h1, 8'h1, 6'd8, 1'b0);
    set_req(1, 32'h2, 8'h1, 6'd8, 1'b0);
    repeat (3) @(negedge bus_clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_spi_valid", 64'(spi_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_abort", 64'(spi_abort), 64'd0);
    req_valid = '0;
    @(posedge bus_clk);
    #1;
    reset_global = 1'b0;
    repeat (2) @(posedge bus_clk);

    // basic write: ss=01 len=24, engine done 30 cycles after accept
    eng_delay = 30;
    eng_rdata = 32'hA5A5_0001;
    g0 = ngnt; r0 = rsp_cnt; n0 = nrise; c0 = cmd_cnt;
    issue(0, 32'h0012_3456, 8'h01, 6'd24, 1'b0, "w_gnt");
    wait_rsp(r0 + 1, "w_rsp_arrive");
    check("w_gnt_id", 64'(gnt_log[g0]), 64'd0);
    check("w_cmd_cnt", 64'(cmd_cnt - c0), 64'd1);
    check("w_cmd_data", 64'(cmd_data), 64'h0012_3456);
    check("w_cmd_ss", 64'(cmd_ss), 64'h01);
    check("w_cmd_len", 64'(cmd_len), 64'd24);
    check("w_issue_lat", 64'(rise_log[n0] - gnt_cyc[g0]), 64'd1);
    check("w_rsp_lat", 64'(rsp_cyc - rise_log[n0]), 64'd31);
    check("w_rsp_vec", 64'(rsp_vec), 64'b01);
    check("w_rsp_err", 64'(rsp_e), 64'd0);
    check("w_rsp_data", 64'(rsp_d), 64'hA5A5_0001);
    wait_idle("w_idle");

    // both requesting: last grant was 0, so order is 1,0,1,0
    eng_delay = 1;
    g0 = ngnt; r0 = rsp_cnt; n0 = nrise;
    @(posedge bus_clk);
    #1;
    req_valid = 2'b11;
    wait_gnt(g0 + 4, "rr_gnt4");
    @(posedge bus_clk);
    #1;
    req_valid = '0;
    wait_rsp(r0 + 4, "rr_rsp4");
    check("rr_g0", 64'(gnt_log[g0]), 64'd1);
    check("rr_g1", 64'(gnt_log[g0 + 1]), 64'd0);
    check("rr_g2", 64'(gnt_log[g0 + 2]), 64'd1);
    check("rr_g3", 64'(gnt_log[g0 + 3]), 64'd0);
    check("rr_space", 64'(rise_log[n0 + 1] - rise_log[n0]), 64'(GAP + 3));
    check("rr_space2", 64'(rise_log[n0 + 3] - rise_log[n0 + 2]), 64'(GAP + 3));
    wait_idle("rr_idle");

    // lock: req1 locked, then unlocked while req0 waits
    g0 = ngnt; r0 = rsp_cnt;
    issue(1, 32'hB1, 8'h02, 6'd16, 1'b1, "lk_gnt_a");
    wait_rsp(r0 + 1, "lk_rsp_a");
    repeat (GAP + 4) @(posedge bus_clk);
    #1;
    check("lk_held_busy", 64'(busy), 64'd1);
    set_req(1, 32'hB2, 8'h02, 6'd16, 1'b0);
    set_req(0, 32'hA0, 8'h01, 6'd16, 1'b0);
    req_valid = 2'b11;
    wait_gnt(g0 + 3, "lk_gnt_c");
    @(posedge bus_clk);
    #1;
    req_valid = '0;
    wait_rsp(r0 + 3, "lk_rsp_c");
    check("lk_g0", 64'(gnt_log[g0]), 64'd1);
    check("lk_g1", 64'(gnt_log[g0 + 1]), 64'd1);
    check("lk_g2", 64'(gnt_log[g0 + 2]), 64'd0);
    wait_idle("lk_released");

    // hung engine with lock requested: abort 64 cycles after issue
    eng_hang = 1'b1;
    r0 = rsp_cnt; n0 = nrise; c0 = abort_cnt;
    issue(0, 32'hDEAD, 8'h02, 6'd8, 1'b1, "to_gnt");
    wait_rsp(r0 + 1, "to_rsp");
    check("to_abort_cnt", 64'(abort_cnt - c0), 64'd1);
    check("to_abort_cyc", 64'(abort_cyc - rise_log[n0]), 64'(TO));
    check("to_rsp_cyc", 64'(rsp_cyc), 64'(abort_cyc));
    check("to_rsp_err", 64'(rsp_e), 64'd1);
    check("to_rsp_data", 64'(rsp_d), 64'd0);
    wait_idle("to_lock_clear");
    eng_hang = 1'b0;

    // rejected commands never reach the engine
    g0 = ngnt; r0 = rsp_cnt; n0 = nrise; c0 = cmd_cnt;
    issue(0, 32'h55, 8'h01, 6'd0, 1'b0, "rj0_gnt");
    wait_rsp(r0 + 1, "rj0_rsp");
    check("rj0_lat", 64'(rsp_cyc - gnt_cyc[g0]), 64'd1);
    check("rj0_err", 64'(rsp_e), 64'd1);
    check("rj0_vec", 64'(rsp_vec), 64'b01);
    wait_idle("rj0_idle");
    issue(1, 32'h66, 8'h01, 6'd33, 1'b0, "rj1_gnt");
    wait_rsp(r0 + 2, "rj1_rsp");
    check("rj1_err", 64'(rsp_e), 64'd1);
    check("rj1_vec", 64'(rsp_vec), 64'b10);
    wait_idle("rj1_idle");
    issue(0, 32'h77, 8'h00, 6'd8, 1'b0, "rj2_gnt");
    wait_rsp(r0 + 3, "rj2_rsp");
    check("rj2_err", 64'(rsp_e), 64'd1);
    wait_idle("rj2_idle");
    check("rj_no_issue", 64'(nrise - n0), 64'd0);
    check("rj_no_cmd", 64'(cmd_cnt - c0), 64'd0);

    // reset during WAIT: req0 leaves pointer at 1, reset restores 0
    eng_delay = 30;
    r0 = rsp_cnt; n0 = nrise;
    issue(0, 32'h99, 8'h01, 6'd8, 1'b0, "rs_gnt");
    repeat (5) @(negedge bus_clk);
    check("rs_pre_busy", 64'(busy), 64'd1);
    #2;
    reset_global = 1'b1;
    #1;
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_spi_valid", 64'(spi_valid), 64'd0);
    check("rs_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(posedge bus_clk);
    #1;
    reset_global = 1'b0;
    repeat (40) @(posedge bus_clk);
    check("rs_no_rsp", 64'(rsp_cnt - r0), 64'd0);
    eng_delay = 1;
    g0 = ngnt;
    @(posedge bus_clk);
    #1;
    set_req(0, 32'h10, 8'h01, 6'd8, 1'b0);
    set_req(1, 32'h20, 8'h01, 6'd8, 1'b0);
    req_valid = 2'b11;
    wait_gnt(g0 + 1, "rs_gnt2");
    @(posedge bus_clk);
    #1;
    req_valid = '0;
    check("rs_first_req0", 64'(gnt_log[g0]), 64'd0);
    wait_rsp(r0 + 1, "rs_rsp2");
    check("rs_rsp_vec", 64'(rsp_vec), 64'b01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
